// File: rtl/i2c_bridge_pkg.sv
// Shared definitions for the I2C-to-SPI bridge: FSM states, default address, byte width.
package i2c_bridge_pkg;
    localparam int         BYTE_W       = 8;
    localparam logic [6:0] DEF_TGT_ADDR = 7'h2A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } i2c_state_t;
endpackage

// File: rtl/i2c_in_filter.sv
// Two-flop synchroniser followed by a stability filter: the output follows the
// synced level only after FILT consecutive equal samples that differ from it.
module i2c_in_filter
    import i2c_bridge_pkg::*;
#(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int             CW   = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(FILT - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // Idle I2C bus is high, so everything resets to 1 to avoid false edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            dout <= 1'b1;
            cnt  <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target front-end: START/STOP detect, address match, byte ACK,
// and a one-byte valid/ready holding register with frame markers.
module i2c_target_rx
    import i2c_bridge_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR = DEF_TGT_ADDR,
    parameter int         FILT     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_start,
    output logic              frame_end,
    output logic              overrun,
    output logic              busy
);
    i2c_state_t  state, nxt;
    logic        scl_f, sda_f, scl_q, sda_q;
    logic        scl_rise, scl_fall, start_c, stop_c;
    logic [6:0]  shift;
    logic [2:0]  bitcnt;
    logic [7:0]  byte_full;
    logic        last_bit, hold_free;
    logic        ack_drv, in_frame;
    logic        shift_en, load, ovf, ack_on, ack_off, fs_set;

    i2c_in_filter #(.FILT(FILT)) u_scl (.clk(clk), .rst(rst), .din(scl_i), .dout(scl_f));
    i2c_in_filter #(.FILT(FILT)) u_sda (.clk(clk), .rst(rst), .din(sda_i), .dout(sda_f));

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_c   = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_c    = scl_f & scl_q & ~sda_q & sda_f;
    assign byte_full = {shift, sda_f};
    assign last_bit  = (bitcnt == 3'd7);
    assign hold_free = ~m_valid | m_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    // Next state; bus conditions override bit handling in every state
    always_comb begin
        nxt = state;
        if (start_c) begin
            nxt = S_ADDR;
        end else if (stop_c) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_ADDR:
                    if (scl_rise && last_bit)
                        nxt = (byte_full[7:1] == TGT_ADDR && !byte_full[0]) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK, S_DATA_ACK:
                    if (scl_fall && ack_drv) nxt = S_DATA;
                S_DATA:
                    if (scl_rise && last_bit) nxt = hold_free ? S_DATA_ACK : S_IGNORE;
                default: nxt = state;
            endcase
        end
    end

    // Outputs and datapath strobes
    always_comb begin
        shift_en = 1'b0;
        load     = 1'b0;
        ovf      = 1'b0;
        ack_on   = 1'b0;
        ack_off  = 1'b0;
        fs_set   = 1'b0;
        sda_oe   = ack_drv;
        if (!start_c && !stop_c) begin
            shift_en = scl_rise && (state == S_ADDR || state == S_DATA);
            load     = (state == S_DATA) && scl_rise && last_bit && hold_free;
            ovf      = (state == S_DATA) && scl_rise && last_bit && !hold_free;
            ack_on   = (state == S_ADDR_ACK || state == S_DATA_ACK) && scl_fall && !ack_drv;
            ack_off  = (state == S_ADDR_ACK || state == S_DATA_ACK) && scl_fall && ack_drv;
            fs_set   = (state == S_ADDR_ACK) && ack_on;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift       <= '0;
            bitcnt      <= '0;
            ack_drv     <= 1'b0;
            in_frame    <= 1'b0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            if (m_valid && m_ready) m_valid <= 1'b0;
            if (start_c || stop_c) begin
                // Partial bits are dropped; an undrained byte stays in the holding reg.
                ack_drv   <= 1'b0;
                bitcnt    <= '0;
                busy      <= start_c;
                frame_end <= in_frame;
                in_frame  <= 1'b0;
            end else begin
                if (shift_en) begin
                    shift  <= byte_full[6:0];
                    bitcnt <= bitcnt + 3'd1;
                end
                if (ack_on)  ack_drv <= 1'b1;
                if (ack_off) ack_drv <= 1'b0;
                if (fs_set) begin
                    frame_start <= 1'b1;
                    in_frame    <= 1'b1;
                end
                if (load) begin
                    m_data  <= byte_full;
                    m_valid <= 1'b1;
                end
                if (ovf) overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C master on a wired-AND SDA line, checked
// against a frame-level model of ACKs, delivered bytes, frame markers and overrun.
module tb_i2c_target_rx;
    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst, scl_m, sda_m, m_ready;
    logic       scl_i, sda_i, sda_oe, m_valid, frame_start, frame_end, overrun, busy;
    logic [7:0] m_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    i2c_target_rx dut (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .frame_start(frame_start), .frame_end(frame_end), .overrun(overrun), .busy(busy)
    );

    // Observed events
    logic [7:0] got_q[$];
    int         fs_cnt = 0, fe_cnt = 0;
    longint     cyc = 0, last_fs_cyc = -1, last_fe_cyc = -1;

    always @(negedge clk) begin
        #2;
        cyc++;
        if (frame_start) begin fs_cnt++; last_fs_cyc = cyc; end
        if (frame_end)   begin fe_cnt++; last_fe_cyc = cyc; end
        if (!rst && m_valid && m_ready) got_q.push_back(m_data);
    end

    // Frame-level reference model state
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    int         exp_fs = 0, exp_fe = 0;
    logic       exp_ovf = 1'b0, model_full = 1'b0, in_frame_m = 1'b0;
    logic [7:0] model_held = 8'h00;
    longint     start_fe_cyc = -1;

    initial begin
        #800000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (!scl_m) begin sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); end
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2*Q);
    endtask

    // mode 1: short SCL pulse in the low phase; mode 2: 1-clk SDA spike while SCL high
    task automatic send_bit(input logic b, input int mode);
        sda_m = b;
        if (mode == 1) begin tick(3); scl_m = 1'b1; tick(2); scl_m = 1'b0; tick(Q-5); end
        else tick(Q);
        scl_m = 1'b1;
        if (mode == 2) begin tick(Q); sda_m = ~b; tick(1); sda_m = b; tick(Q-1); end
        else tick(2*Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gbit, input int gmode, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], (i == gbit) ? gmode : 0);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        ack = sda_oe;
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic end_frame();
        bus_stop();
        if (in_frame_m) exp_fe++;
        in_frame_m = 1'b0;
    endtask

    task automatic do_frame(input string tag, input logic [7:0] ab, input logic rdy,
                            input bit stop_after, input int gbit, input int gmode);
        logic ack, ign, exp_ack;
        m_ready = rdy;
        if (rdy && model_full) begin exp_q.push_back(model_held); model_full = 1'b0; end
        bus_start();
        start_fe_cyc = last_fe_cyc;
        if (in_frame_m) exp_fe++;
        in_frame_m = 1'b0;
        send_byte(ab, -1, 0, ack);
        ign = (ab != 8'h54);
        chk({tag, " addr ack"}, ack, !ign);
        if (!ign) begin exp_fs++; in_frame_m = 1'b1; end
        foreach (tx_q[i]) begin
            exp_ack = !ign && (rdy || !model_full);
            send_byte(tx_q[i], (i == 0) ? gbit : -1, gmode, ack);
            chk({tag, " data ack"}, ack, exp_ack);
            if (exp_ack) begin
                if (rdy) exp_q.push_back(tx_q[i]);
                else begin model_full = 1'b1; model_held = tx_q[i]; end
            end else if (!ign) begin
                exp_ovf = 1'b1;
                ign = 1'b1;
            end
        end
        if (stop_after) end_frame();
    endtask

    task automatic check_totals(input string tag);
        tick(Q);
        chk({tag, " byte count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, " byte"}, got_q[i], exp_q[i]);
        chk({tag, " frame_start count"}, fs_cnt, exp_fs);
        chk({tag, " frame_end count"}, fe_cnt, exp_fe);
        chk({tag, " overrun"}, overrun, exp_ovf);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic       ack;
        logic [7:0] ab;
        logic       rdy;
        int         n;
        longint     prev_fs;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; m_ready = 1'b0;
        tick(5);
        chk("rst sda_oe", sda_oe, 0);
        chk("rst m_valid", m_valid, 0);
        chk("rst m_data", m_data, 0);
        chk("rst frame_start", frame_start, 0);
        chk("rst frame_end", frame_end, 0);
        chk("rst overrun", overrun, 0);
        chk("rst busy", busy, 0);
        rst = 1'b0;
        tick(10);

        // Addressed write, two bytes
        tx_q = {8'hA5, 8'h3C};
        do_frame("t1", 8'h54, 1'b1, 1'b1, -1, 0);
        check_totals("t1");

        // Wrong address
        tx_q = {8'h77};
        do_frame("t2", 8'h56, 1'b1, 1'b1, -1, 0);
        check_totals("t2");

        // Read to our address: NACK, ignored until STOP
        tx_q = {8'h99};
        do_frame("t3", 8'h55, 1'b1, 1'b0, -1, 0);
        chk("t3 busy before stop", busy, 1);
        end_frame();
        tick(Q);
        chk("t3 busy after stop", busy, 0);
        check_totals("t3");

        // Holding register full -> second byte dropped
        tx_q = {8'h11, 8'h22};
        do_frame("t4", 8'h54, 1'b0, 1'b1, -1, 0);
        tick(Q);
        chk("t4 m_valid held", m_valid, 1);
        chk("t4 m_data held", m_data, 8'h11);
        check_totals("t4");

        // Repeated START between two frames
        tx_q = {8'h5A, 8'hC3};
        do_frame("t5a", 8'h54, 1'b1, 1'b0, -1, 0);
        prev_fs = last_fs_cyc;
        tx_q = {8'h0F};
        do_frame("t5b", 8'h54, 1'b1, 1'b1, -1, 0);
        chk("t5 frame_end between frames", (start_fe_cyc > prev_fs) && (start_fe_cyc < last_fs_cyc), 1);
        check_totals("t5");

        // Glitch rejection
        tx_q = {8'h96};
        do_frame("t6 scl glitch", 8'h54, 1'b1, 1'b1, 3, 1);
        tx_q = {8'h69};
        do_frame("t6 sda spike", 8'h54, 1'b1, 1'b1, 2, 2);
        check_totals("t6");

        // Reset during an ACK slot
        m_ready = 1'b1;
        bus_start();
        ab = 8'h54;
        for (int i = 7; i >= 0; i--) send_bit(ab[i], 0);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        chk("t7 ack before rst", sda_oe, 1);
        exp_fs++;
        rst = 1'b1;
        tick(1);
        chk("t7 sda_oe after rst", sda_oe, 0);
        chk("t7 busy after rst", busy, 0);
        rst = 1'b0;
        exp_ovf = 1'b0; model_full = 1'b0; in_frame_m = 1'b0;
        tick(Q);
        scl_m = 1'b0; tick(Q);
        send_byte(8'hAB, -1, 0, ack);
        chk("t7 ignored after rst", ack, 0);
        bus_stop();
        check_totals("t7");

        // Randomized frames
        for (int r = 0; r < 8; r++) begin
            ab  = ($urandom_range(0, 2) != 0) ? 8'h54 : 8'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            n   = $urandom_range(1, 3);
            tx_q.delete();
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            do_frame("rand", ab, rdy, 1'b1, -1, 0);
        end
        m_ready = 1'b1;
        if (model_full) begin exp_q.push_back(model_held); model_full = 1'b0; end
        check_totals("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
